// File: rtl/seq_addsub_unit.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock with a
// registered inter-chunk carry, start/busy/done handshake and ALU flags.
module seq_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             neg1,
  input  logic             neg2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_addsub_unit: WIDTH must be an integer multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Two's-complement negate when requested; wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                   input logic neg);
    if (neg) cond_negate = ~v + ONE;
    else     cond_negate = v;
  endfunction

  state_t           state_r, state_next_s;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] sop1_r, sop2_r, acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             busy_r, done_r, carry_out_r, overflow_r, zero_r, negative_r;

  logic [CHUNK-1:0] chunk_a_s, chunk_b_s;
  logic [CHUNK:0]   chunk_sum_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             last_s;

  // Select the active chunk, add it with the registered carry, merge into accumulator.
  always_comb begin
    chunk_a_s  = {CHUNK{1'b0}};
    chunk_b_s  = {CHUNK{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (idx_r == IW'(i)) begin
        chunk_a_s = sop1_r[i*CHUNK +: CHUNK];
        chunk_b_s = sop2_r[i*CHUNK +: CHUNK];
      end else begin
        chunk_a_s = chunk_a_s;
        chunk_b_s = chunk_b_s;
      end
    end
    chunk_sum_s = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{CHUNK{1'b0}}, carry_r};
    acc_next_s  = acc_r;
    for (int i = 0; i < N; i++) begin
      if (idx_r == IW'(i)) begin
        acc_next_s[i*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
      end else begin
        acc_next_s = acc_next_s;
      end
    end
    last_s = (idx_r == IW'(N-1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = IDLE;
        else        state_next_s = RUN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, chunk sequencing and registered result/flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r       <= {IW{1'b0}};
      carry_r     <= 1'b0;
      sop1_r      <= {WIDTH{1'b0}};
      sop2_r      <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      negative_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sop1_r  <= cond_negate(operand1, neg1);
            sop2_r  <= cond_negate(operand2, neg2);
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IW{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          acc_r   <= acc_next_s;
          carry_r <= chunk_sum_s[CHUNK];
          if (last_s) begin
            // Final chunk: publish result and all flags together.
            idx_r       <= {IW{1'b0}};
            sum_r       <= acc_next_s;
            carry_out_r <= chunk_sum_s[CHUNK];
            overflow_r  <= (sop1_r[WIDTH-1] == sop2_r[WIDTH-1]) &&
                           (acc_next_s[WIDTH-1] != sop1_r[WIDTH-1]);
            zero_r      <= (acc_next_s == {WIDTH{1'b0}});
            negative_r  <= acc_next_s[WIDTH-1];
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            idx_r       <= idx_r + IW'(1);
            busy_r      <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;
  assign zero      = zero_r;
  assign negative  = negative_r;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed self-checking bench for seq_addsub_unit (32/8 main instance, 16/16 single-cycle instance).
module tb_seq_addsub_unit;

  logic        clk;
  logic        reset_n;
  logic        start, neg1, neg2;
  logic [31:0] operand1, operand2;
  logic        busy, done, carry_out, overflow, zero, negative;
  logic [31:0] sum;

  logic        start16, neg1_16, neg2_16;
  logic [15:0] operand1_16, operand2_16;
  logic        busy16, done16, carry_out16, overflow16, zero16, negative16;
  logic [15:0] sum16;

  int n_cmp = 0;
  int n_err = 0;

  seq_addsub_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .operand1(operand1), .operand2(operand2), .neg1(neg1), .neg2(neg2),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  seq_addsub_unit #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16),
    .operand1(operand1_16), .operand2(operand2_16), .neg1(neg1_16), .neg2(neg2_16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(carry_out16),
    .overflow(overflow16), .zero(zero16), .negative(negative16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] flags32();
    return {28'd0, carry_out, overflow, zero, negative};
  endfunction

  // Waits (bounded) for done on the 32-bit instance; cyc = edges waited.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  // Called 1 time unit after a clock edge; flags ordered {carry, overflow, zero, negative}.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic n1, input logic n2,
                        input logic [31:0] exp_sum, input logic [3:0] exp_flags);
    int cyc;
    operand1 = a; operand2 = b; neg1 = n1; neg2 = n2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand1 = 32'hDEAD_BEEF; operand2 = 32'h1234_5678; neg1 = 1'b1; neg2 = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_nodone"}, {31'd0, done}, 32'd0);
    wait_done(tag, cyc);
    check_eq({tag, "_lat"}, cyc, 32'd4);
    check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_sum"}, sum, exp_sum);
    check_eq({tag, "_flags"}, flags32(), {28'd0, exp_flags});
  endtask

  initial begin
    int cyc;
    int done_seen;
    reset_n = 1'b0; start = 1'b0; neg1 = 1'b0; neg2 = 1'b0;
    operand1 = 32'd0; operand2 = 32'd0;
    start16 = 1'b0; neg1_16 = 1'b0; neg2_16 = 1'b0;
    operand1_16 = 16'd0; operand2_16 = 16'd0;
    #3;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_sum", sum, 32'd0);
    check_eq("rst_flags", flags32(), 32'd0);
    #9 reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("add5_7",   32'd5,          32'd7,          1'b0, 1'b0, 32'h0000_000C, 4'b0000);
    run_op("sub5_7",   32'd5,          32'd7,          1'b0, 1'b1, 32'hFFFF_FFFE, 4'b0001);
    run_op("ovf_pos",  32'h7FFF_FFFF,  32'h0000_0001,  1'b0, 1'b0, 32'h8000_0000, 4'b0101);
    run_op("wrap_all", 32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 1'b0, 32'h0000_0000, 4'b1010);
    run_op("chunk_cy", 32'h0000_00FF,  32'h0000_0001,  1'b0, 1'b0, 32'h0000_0100, 4'b0000);
    run_op("neg_min",  32'h8000_0000,  32'h0000_0000,  1'b1, 1'b0, 32'h8000_0000, 4'b0001);
    run_op("neg_both", 32'd3,          32'd4,          1'b1, 1'b1, 32'hFFFF_FFF9, 4'b1001);

    // start pulsed during busy is ignored
    operand1 = 32'd1; operand2 = 32'd1; neg1 = 1'b0; neg2 = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    operand1 = 32'd9; operand2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", cyc);
    check_eq("ign_sum", sum, 32'd2);
    @(posedge clk); #1;
    check_eq("ign_idle", {31'd0, busy}, 32'd0);

    // start held high across done: second op captured in the done cycle
    operand1 = 32'd2; operand2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    operand1 = 32'd10; operand2 = 32'd20;
    wait_done("b2b1", cyc);
    check_eq("b2b1_sum", sum, 32'd5);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b_done_drop", {31'd0, done}, 32'd0);
    check_eq("b2b_busy_rise", {31'd0, busy}, 32'd1);
    wait_done("b2b2", cyc);
    check_eq("b2b2_lat", cyc + 1, 32'd5);
    check_eq("b2b2_sum", sum, 32'd30);

    // asynchronous reset in the middle of an operation
    @(posedge clk); #1;
    operand1 = 32'd5; operand2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    check_eq("arst_sum", sum, 32'd0);
    check_eq("arst_flags", flags32(), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check_eq("arst_no_done", done_seen, 32'd0);
    check_eq("arst_idle", {31'd0, busy}, 32'd0);

    // single-chunk instance: done one cycle after start
    operand1_16 = 16'd5; operand2_16 = 16'd7; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    check_eq("w16_busy", {31'd0, busy16}, 32'd1);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done16) break;
    end
    check_eq("w16_done", {31'd0, done16}, 32'd1);
    check_eq("w16_lat", cyc, 32'd1);
    check_eq("w16_sum", {16'd0, sum16}, 32'h0000_000C);
    check_eq("w16_flags", {28'd0, carry_out16, overflow16, zero16, negative16}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_addsub_unit.md
Name: seq_addsub_unit

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor for the stack CPU datapath.
- Per-operand negate controls (neg1/neg2) select a+b, a-b, -a+b or -a-b.
- Adds CHUNK bits per clock through a registered inter-chunk carry, so WIDTH is not limited by a single ripple path.
- Uses a start/busy/done handshake and returns carry, overflow, zero and negative flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH must be an integer multiple of CHUNK; elaboration error otherwise.
- N (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled on the clock edge; accepted only when busy=0.
- operand1  input  WIDTH  first operand. Captured on accepted start.
- operand2  input  WIDTH  second operand. Captured on accepted start.
- neg1  input  1  negate operand1 (two's complement) before the add.
- neg2  input  1  negate operand2 before the add.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result and flags valid and updated.
- sum  output  WIDTH  registered result. Holds its value until the next done.
- carry_out  output  1  carry out of bit WIDTH-1 of sop1+sop2.
- overflow  output  1  signed overflow of sop1+sop2.
- zero  output  1  sum == 0.
- negative  output  1  sum[WIDTH-1].

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, chunk index=0, internal carry=0. Outputs: busy=0, done=0, sum=0, carry_out=0, overflow=0, zero=0, negative=0.
- Reset asserted mid-operation aborts the operation. No done is produced; outputs take their reset values.
- Operand capture on an accepted start edge:
  - sop1 = neg1 ? (~operand1+1) : operand1, and likewise for sop2. Both are taken modulo 2^WIDTH.
  - Negating the most-negative value, or 0, wraps to itself. No flag is raised for this.
- FSM states are IDLE and RUN.
  - IDLE: start=1 latches sop1, sop2, clears the internal carry and index, then goes to RUN. done is cleared to 0 on any edge in IDLE.
  - RUN: each edge adds chunk[idx] of sop1 and sop2 plus the registered carry, writes chunk[idx] of the accumulator, updates the carry and increments idx.
  - RUN, at the edge processing idx=N-1: the full result is written to sum, flags are updated, done=1, busy=0, and the FSM returns to IDLE.
- Timing:
  - busy=1 from the edge after the accepted start through the final chunk edge.
  - If start is sampled at edge k, done=1 during the cycle after edge k+N. Latency is N cycles.
  - With CHUNK=WIDTH (N=1), done follows start by one cycle.
- Back-to-back: start=1 during a done=1 cycle is accepted, because the FSM is in IDLE. done then drops and busy rises on that edge, giving one result every N+1 cycles.
- start while busy=1 is ignored. Captured operands are unaffected by input changes after capture.
- Flags:
  - carry_out is the final chunk carry.
  - overflow = (sop1[MSB]==sop2[MSB]) && (sum[MSB]!=sop1[MSB]).
  - zero and negative are computed from the final sum.
  - All flags are registered together with sum and change only at done.
- Carry must propagate correctly across chunk boundaries. An intermediate chunk carry must not leak into the next operation.

Test Plan (WIDTH=32, CHUNK=8, N=4 unless noted):
- 5+7, neg1=neg2=0, start at edge k → busy high on edges k+1..k+4, done pulse after edge k+4; sum=0x0000000C, all flags 0.
- 5, 7, neg2=1 → sum=0xFFFFFFFE, negative=1, carry_out=0, overflow=0, zero=0.
- 0x7FFFFFFF + 0x00000001 → sum=0x80000000, overflow=1, negative=1, carry_out=0. Then 0xFFFFFFFF + 1 → sum=0, zero=1, carry_out=1 (carry ripples through all 4 chunks).
- neg1=1, operand1=0x80000000, operand2=0 → sum=0x80000000, negative=1, overflow=0. Also neg1=neg2=1 with 3, 4 → sum=0xFFFFFFF9, carry_out=1.
- Start 1+1, pulse start with 9+9 at cycle 2 of busy → ignored; result=2. Start held high across done → second operation captured at the done cycle, next done 5 cycles later.
- reset_n low at cycle 2 of RUN → busy=0, done=0, sum=0 immediately (asynchronous), no done pulse after release. Repeat scenario 1 with WIDTH=16, CHUNK=16 → done one cycle after start, sum=0x000C.
